// File: rtl/clock_pkg.sv
// Shared definitions for the front-panel button conditioner.
//   btn_state_t  : arbitration FSM states (IDLE, HOLD, REPEAT, LOCK)
//   DIR_*        : encoding of the latched up/down direction
//   BTN_*        : bit positions of the three buttons in packed button vectors
//   cnt_width()  : bits needed to count 0..max_count (never less than 1)
//   max_int()    : larger of two integers, for sizing shared timers
package clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2,
        LOCK   = 2'd3
    } btn_state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_CLEAR = 2;
    localparam int NUM_BTNS  = 3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Two-flop synchroniser followed by a debounce counter for one raw button.
//   i_clk, i_rstn : clock, asynchronous active-low reset
//   i_btn         : raw asynchronous button level
//   o_d           : debounced level; changes only after DEBOUNCE_CYCLES
//                   consecutive synchronised samples that disagree with it
//   o_rise        : one-cycle pulse in the cycle o_d becomes 1
module button_debouncer
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn,
    output logic o_d,
    output logic o_rise
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             d_reg;
    logic             rise_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            d_reg     <= 1'b0;
            rise_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= i_btn;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            if (sync2_reg != d_reg) begin
                // The sample that completes the run flips the state directly,
                // so the flip lands on the DEBOUNCE_CYCLES-th disagreeing edge.
                if (cnt_reg == CNT_LAST) begin
                    d_reg    <= sync2_reg;
                    rise_reg <= sync2_reg;
                    cnt_reg  <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign o_d    = d_reg;
    assign o_rise = rise_reg;

endmodule

// File: rtl/clock_button_conditioner.sv
// Turns the raw up/down/clear front-panel buttons into single-cycle command
// pulses for the BCD up/down counter. o_up and o_down are never high together.
//   i_clk, i_rstn                     : clock, asynchronous active-low reset
//   i_btn_up, i_btn_down, i_btn_clear : raw asynchronous buttons, active-high
//   o_up, o_down, o_clear             : registered one-cycle command pulses
//   o_repeating                       : high while auto-repeat is running
// Build option: define CLOCK_BTN_AUTOREPEAT_EN to build the long-press
// auto-repeat (HOLD timer and REPEAT state). Without it, a held button gives
// exactly one pulse and o_repeating is tied low.
module clock_button_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int REPEAT_CYCLES   = 5000000
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_btn_up,
    input  logic i_btn_down,
    input  logic i_btn_clear,
    output logic o_up,
    output logic o_down,
    output logic o_clear,
    output logic o_repeating
);

    logic [NUM_BTNS-1:0] btn_raw;
    logic [NUM_BTNS-1:0] d_vec;
    logic [NUM_BTNS-1:0] rise_vec;

    assign btn_raw[BTN_UP]    = i_btn_up;
    assign btn_raw[BTN_DOWN]  = i_btn_down;
    assign btn_raw[BTN_CLEAR] = i_btn_clear;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_deb
            button_debouncer #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_deb (
                .i_clk (i_clk),
                .i_rstn(i_rstn),
                .i_btn (btn_raw[gi]),
                .o_d   (d_vec[gi]),
                .o_rise(rise_vec[gi])
            );
        end
    endgenerate

    logic d_up, d_down, d_clear;
    logic rise_up, rise_down, rise_clear;
    assign d_up       = d_vec[BTN_UP];
    assign d_down     = d_vec[BTN_DOWN];
    assign d_clear    = d_vec[BTN_CLEAR];
    assign rise_up    = rise_vec[BTN_UP];
    assign rise_down  = rise_vec[BTN_DOWN];
    assign rise_clear = rise_vec[BTN_CLEAR];

    btn_state_t state_reg, state_next;
    logic       dir_reg, dir_next;
    logic       up_reg, up_next;
    logic       down_reg, down_next;
    logic       clear_reg;
    logic       dir_held;
    logic       opp_rise;

    // Level of the button that started the current press, and a fresh press
    // of the other one (which aborts the press into LOCK).
    assign dir_held = (dir_reg == DIR_DOWN) ? d_down : d_up;
    assign opp_rise = (dir_reg == DIR_DOWN) ? rise_up : rise_down;

`ifdef CLOCK_BTN_AUTOREPEAT_EN
    localparam int TMR_W = cnt_width(max_int(HOLD_CYCLES, REPEAT_CYCLES));
    localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

    logic [TMR_W-1:0] tmr_reg, tmr_next;
    logic             tmr_done;

    assign tmr_done = (state_reg == HOLD) ? (tmr_reg == HOLD_LAST)
                                          : (tmr_reg == REPEAT_LAST);
`endif

    always_comb begin
        state_next = state_reg;
        dir_next   = dir_reg;
        up_next    = 1'b0;
        down_next  = 1'b0;
`ifdef CLOCK_BTN_AUTOREPEAT_EN
        tmr_next   = tmr_reg;
`endif
        if (d_clear) begin
            // Clear owns the counter for as long as it is held.
            state_next = LOCK;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (rise_up && rise_down) begin
                        state_next = LOCK;
                    end else if (rise_up || rise_down) begin
                        dir_next   = rise_down ? DIR_DOWN : DIR_UP;
                        up_next    = rise_up;
                        down_next  = rise_down;
                        state_next = HOLD;
`ifdef CLOCK_BTN_AUTOREPEAT_EN
                        tmr_next   = '0;
`endif
                    end
                end
                HOLD, REPEAT: begin
                    if (opp_rise) begin
                        state_next = LOCK;
                    end else if (!dir_held) begin
                        state_next = IDLE;
                    end else begin
`ifdef CLOCK_BTN_AUTOREPEAT_EN
                        if (tmr_done) begin
                            up_next    = (dir_reg == DIR_UP);
                            down_next  = (dir_reg == DIR_DOWN);
                            tmr_next   = '0;
                            state_next = REPEAT;
                        end else begin
                            tmr_next = tmr_reg + TMR_W'(1);
                        end
`endif
                    end
                end
                LOCK: begin
                    if (!d_up && !d_down) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= IDLE;
            dir_reg   <= DIR_UP;
            up_reg    <= 1'b0;
            down_reg  <= 1'b0;
            clear_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            dir_reg   <= dir_next;
            up_reg    <= up_next;
            down_reg  <= down_next;
            clear_reg <= rise_clear;
        end
    end

`ifdef CLOCK_BTN_AUTOREPEAT_EN
    logic repeating_reg;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tmr_reg       <= '0;
            repeating_reg <= 1'b0;
        end else begin
            tmr_reg       <= tmr_next;
            repeating_reg <= (state_next == REPEAT);
        end
    end

    assign o_repeating = repeating_reg;
`else
    assign o_repeating = 1'b0;
`endif

    assign o_up    = up_reg;
    assign o_down  = down_reg;
    assign o_clear = clear_reg;

endmodule

// File: tb/tb_clock_button_conditioner.sv
module tb_clock_button_conditioner;

    localparam int DEB  = 4;
    localparam int HOLD = 20;
    localparam int REP  = 5;
`ifdef CLOCK_BTN_AUTOREPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic b_up = 1'b0, b_down = 1'b0, b_clear = 1'b0;
    logic o_up, o_down, o_clear, o_repeating;

    always #5 clk = ~clk;

    clock_button_conditioner #(
        .DEBOUNCE_CYCLES(DEB),
        .HOLD_CYCLES    (HOLD),
        .REPEAT_CYCLES  (REP)
    ) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_btn_up   (b_up),
        .i_btn_down (b_down),
        .i_btn_clear(b_clear),
        .o_up       (o_up),
        .o_down     (o_down),
        .o_clear    (o_clear),
        .o_repeating(o_repeating)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    bit rst_req = 1'b1;
    int up_edges[$];
    int down_edges[$];
    int clear_edges[$];
    int rep_cycles = 0;

    // Reference model: button levels judged by their recent sample history,
    // pulse times computed arithmetically from the press start time.
    bit m_s1[3], m_s2[3], m_d[3], m_dlast[3];
    bit m_hist[3][$];
    int m_mode;   // 0 idle, 1 press active, 2 locked
    bit m_dir;    // 0 up, 1 down
    int m_t0;
    bit e_up, e_down, e_clear, e_rep;

    function automatic void model_reset();
        for (int b = 0; b < 3; b++) begin
            m_s1[b] = 0; m_s2[b] = 0; m_d[b] = 0; m_dlast[b] = 0;
            m_hist[b].delete();
        end
        m_mode = 0; m_dir = 0; m_t0 = 0;
        e_up = 0; e_down = 0; e_clear = 0; e_rep = 0;
    endfunction

    function automatic void model_edge(input bit r_up, input bit r_down, input bit r_clear);
        bit raw[3];
        bit dd[3];
        bit rr[3];
        bit flip;
        int el;
        raw[0] = r_up; raw[1] = r_down; raw[2] = r_clear;
        for (int b = 0; b < 3; b++) begin
            dd[b] = m_d[b];
            rr[b] = m_d[b] & ~m_dlast[b];
            m_dlast[b] = m_d[b];
            m_hist[b].push_back(m_s2[b]);
            if (m_hist[b].size() > DEB) void'(m_hist[b].pop_front());
            if (m_hist[b].size() == DEB) begin
                flip = 1;
                for (int i = 0; i < DEB; i++) if (m_hist[b][i] == m_d[b]) flip = 0;
                if (flip) m_d[b] = ~m_d[b];
            end
            m_s2[b] = m_s1[b];
            m_s1[b] = raw[b];
        end
        e_up = 0; e_down = 0; e_clear = rr[2];
        if (dd[2]) begin
            m_mode = 2;
        end else begin
            case (m_mode)
                0: begin
                    if (rr[0] && rr[1]) m_mode = 2;
                    else if (rr[0] || rr[1]) begin
                        m_mode = 1; m_dir = rr[1]; m_t0 = cyc;
                        e_up = rr[0]; e_down = rr[1];
                    end
                end
                1: begin
                    el = cyc - m_t0;
                    if (rr[m_dir ? 0 : 1]) m_mode = 2;
                    else if (!dd[m_dir]) m_mode = 0;
                    else if (AUTO && (el == HOLD || (el > HOLD && (el - HOLD) % REP == 0))) begin
                        e_up = ~m_dir; e_down = m_dir;
                    end
                end
                default: if (!dd[0] && !dd[1] && !dd[2]) m_mode = 0;
            endcase
        end
        e_rep = AUTO && (m_mode == 1) && ((cyc - m_t0) >= HOLD);
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s at cycle %0d: got %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        tests_run++;
        assert (obs == exp) else begin
            tests_failed++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, sample 1 time unit after the rise.
    task automatic step(input bit up, input bit down, input bit clear);
        @(negedge clk);
        b_up = up; b_down = down; b_clear = clear;
        rstn = ~rst_req;
        @(posedge clk);
        cyc++;
        if (rst_req) model_reset();
        else model_edge(up, down, clear);
        #1;
        check("o_up", o_up, e_up);
        check("o_down", o_down, e_down);
        check("o_clear", o_clear, e_clear);
        check("o_repeating", o_repeating, e_rep);
        check("up_down_exclusive", o_up & o_down, 1'b0);
        if (o_up) up_edges.push_back(cyc);
        if (o_down) down_edges.push_back(cyc);
        if (o_clear) clear_edges.push_back(cyc);
        if (o_repeating) rep_cycles++;
    endtask

    task automatic hold(input bit up, input bit down, input bit clear, input int n);
        for (int i = 0; i < n; i++) step(up, down, clear);
    endtask

    int p, nu, nd, nc, nr;

    initial begin
        model_reset();
        // Reset state
        rst_req = 1'b1;
        hold(0, 0, 0, 3);
        rst_req = 1'b0;
        hold(0, 0, 0, 5);

        // 1: clean up press, pulse on the 7th edge counting the sampling edge
        nu = up_edges.size(); nd = down_edges.size(); nc = clear_edges.size();
        p = cyc + 1;
        hold(1, 0, 0, 10);
        hold(0, 0, 0, 15);
        check_int("s1_up_count", up_edges.size() - nu, 1);
        check_int("s1_up_edge", up_edges[up_edges.size() - 1], p + DEB + 2);
        check_int("s1_down_count", down_edges.size() - nd, 0);
        check_int("s1_clear_count", clear_edges.size() - nc, 0);

        // 2: bouncing press then steady high
        nu = up_edges.size();
        for (int i = 0; i < 3; i++) begin
            hold(1, 0, 0, 2);
            hold(0, 0, 0, 2);
        end
        p = cyc + 1;
        hold(1, 0, 0, 12);
        hold(0, 0, 0, 15);
        check_int("s2_up_count", up_edges.size() - nu, 1);
        check_int("s2_up_edge", up_edges[up_edges.size() - 1], p + DEB + 2);

        // 3: down held 60 cycles
        nd = down_edges.size(); nr = rep_cycles;
        p = cyc + 1;
        hold(0, 1, 0, 60);
        hold(0, 0, 0, 15);
        check_int("s3_down_count", down_edges.size() - nd, AUTO ? 9 : 1);
        check_int("s3_first_down", down_edges[nd], p + DEB + 2);
        check_int("s3_repeat_cycles", rep_cycles - nr, AUTO ? 40 : 0);

        // 4: opposite button while up held, then a fresh up press
        nu = up_edges.size(); nd = down_edges.size();
        hold(1, 0, 0, 10);
        hold(1, 1, 0, 10);
        hold(0, 1, 0, 5);
        hold(0, 0, 0, 15);
        check_int("s4_up_count", up_edges.size() - nu, 1);
        check_int("s4_down_count", down_edges.size() - nd, 0);
        nu = up_edges.size();
        hold(1, 0, 0, 10);
        hold(0, 0, 0, 15);
        check_int("s4_fresh_up", up_edges.size() - nu, 1);

        // 5a: up and down in the same cycle
        nu = up_edges.size(); nd = down_edges.size();
        hold(1, 1, 0, 10);
        hold(0, 0, 0, 15);
        check_int("s5_both_up", up_edges.size() - nu, 0);
        check_int("s5_both_down", down_edges.size() - nd, 0);

        // 5b: clear during up auto-repeat
        nu = up_edges.size(); nc = clear_edges.size();
        hold(1, 0, 0, 35);
        hold(1, 0, 1, 10);
        hold(1, 0, 0, 10);
        hold(0, 0, 0, 20);
        check_int("s5_clear_count", clear_edges.size() - nc, 1);
        check_int("s5_up_count", up_edges.size() - nu, AUTO ? 4 : 1);
        check_int("s5_up_after_clear",
                  int'(up_edges[up_edges.size() - 1] > clear_edges[clear_edges.size() - 1]), 0);

        // 6: reset mid-REPEAT with up still held
        hold(1, 0, 0, 35);
        rst_req = 1'b1;
        hold(1, 0, 0, 4);
        rst_req = 1'b0;
        nu = up_edges.size();
        p = cyc + 1;
        hold(1, 0, 0, 30);
        hold(0, 0, 0, 15);
        check_int("s6_up_count", up_edges.size() - nu, AUTO ? 3 : 1);
        check_int("s6_first_up", up_edges[nu], p + DEB + 2);

        // Random segments against the model
        for (int s = 0; s < 60; s++) begin
            bit ru, rd, rc;
            int len;
            ru = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            rc = ($urandom_range(0, 5) == 0);
            len = $urandom_range(1, 40);
            hold(ru, rd, rc, len);
        end
        hold(0, 0, 0, 20);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/clock_button_conditioner.md
Name: clock_button_conditioner

Overview:
Conditions the three raw front-panel buttons (up, down, clear) into clean single-cycle command pulses for the 0–99 BCD up/down counter stage. Each button passes through a synchroniser and a debouncer. An up/down arbitration FSM then issues pulses, with optional long-press auto-repeat. The outputs drive the counter's i_up, i_down and i_clear inputs directly, so o_up and o_down are never high in the same cycle.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable synchronised samples needed to change a debounced state (≥1)
HOLD_CYCLES, 25000000, cycles from the first pulse to the first auto-repeat pulse (≥2)
REPEAT_CYCLES, 5000000, cycles between successive auto-repeat pulses (≥2)

Ports:
i_clk  in  1  system clock
i_rstn  in  1  reset, asynchronous, active-low
i_btn_up  in  1  raw up button, asynchronous, active-high
i_btn_down  in  1  raw down button, asynchronous, active-high
i_btn_clear  in  1  raw clear button, asynchronous, active-high
o_up  out  1  one-cycle increment pulse
o_down  out  1  one-cycle decrement pulse
o_clear  out  1  one-cycle clear pulse
o_repeating  out  1  level; high while the FSM is in REPEAT

Behaviour:
- Reset (async, i_rstn low): all synchroniser flops, debounced states, counters and outputs go to 0; FSM goes to IDLE. All outputs are registered.
- Synchroniser: two flops per button; the output is s_x.
- Debouncer:
  - Debounced state d_x flips when s_x != d_x for DEBOUNCE_CYCLES consecutive edges.
  - Any sample with s_x == d_x zeroes the counter.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Latency: o_up, o_down or o_clear asserts exactly DEBOUNCE_CYCLES+3 edges after the first edge that samples the raw button high and stable.
- o_clear: one pulse on each d_clear rising edge; never repeats.
- Clear priority: while d_clear is 1, the FSM is forced to LOCK and o_up/o_down stay 0.
- FSM states IDLE, HOLD, REPEAT, LOCK; registers dir (0 = up, 1 = down) and tmr (width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1)).
  - IDLE:
    - Exactly one of d_up/d_down rises → emit one pulse on the matching output, latch dir, tmr = 0, go to HOLD.
    - Both rise in the same cycle, or d_clear is 1 → LOCK, no pulse.
  - HOLD:
    - tmr increments each cycle.
    - When tmr == HOLD_CYCLES-1 with the dir button still held → pulse, tmr = 0, go to REPEAT.
  - REPEAT:
    - o_repeating = 1.
    - Pulse whenever tmr == REPEAT_CYCLES-1, then tmr = 0.
  - Release: in HOLD or REPEAT, the dir button's debounced state falling → IDLE; no pulse in that cycle.
  - Opposite button: its debounced state rising while in HOLD or REPEAT → LOCK; no pulse.
  - LOCK: no pulses; return to IDLE only when d_up, d_down and d_clear are all 0.
- Pulse train while held: pulses at T, T+HOLD_CYCLES, T+HOLD_CYCLES+REPEAT_CYCLES, and every REPEAT_CYCLES after that.
- Button held across reset release: debounced states restart at 0, so the press is seen as new and produces a pulse after the normal latency.

Optional Feature:
CLOCK_BTN_AUTOREPEAT_EN
- Defined: HOLD and REPEAT behave as described above.
- Undefined: the HOLD timer, REPEAT state and tmr are not built. After the first pulse the FSM waits in HOLD (no timer) until release or until the opposite button/clear sends it to LOCK. o_repeating is tied to 0.

Decomposition:
- Shared package clock_pkg holds:
  - the FSM state enum (btn_state_t: IDLE, HOLD, REPEAT, LOCK);
  - the localparam width helpers;
  - the direction encoding constants.
- One sub-module: button_debouncer (two-flop synchroniser plus debounce counter, parameter DEBOUNCE_CYCLES, outputs d and rise). It is instantiated three times.

Test Plan:
Use DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=5 for all scenarios.
1. Clean up press held 10 cycles → single o_up at edge 7 after the press; o_down and o_clear stay 0.
2. Up press bouncing 0/1 every 2 cycles for 12 cycles, then steady high → exactly one o_up, 7 edges after steady high begins.
3. Down held 60 cycles (AUTOREPEAT_EN defined) → o_down at T, T+20, T+25, T+30, …; o_repeating high from T+20 until release; undefined macro → only the pulse at T.
4. Up held, then down pressed while up still held → no o_down; no further o_up until both are released; a fresh up press then yields o_up.
5. Up and down pressed in the same cycle → no pulses; clear pressed during an up auto-repeat → one o_clear, o_up stops immediately.
6. i_rstn pulsed low mid-REPEAT with up still held → outputs 0 during reset; after release one o_up at the normal latency, then the HOLD spacing restarts.
